fetch_stage: RTL

//   IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory request port and IF/ID latch.

---
 rtl/fetch_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory req/ack port and the IF/ID latch.
// A single-entry hold buffer keeps a word that returns while D is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_i,
  input  logic        stall_i,
  output logic [31:0] pc_f,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_busy,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        adel_d
);

  typedef enum logic [0:0] {StReq, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d_q;
  logic [31:0] instr_d_q;
  logic        valid_d_q;
  logic        adel_d_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_instr_q;

  logic        addr_bad;
  logic        below_base;
  logic        above_top;
  logic [32:0] win_top;

  // 33-bit window bounds so BASE+SIZE cannot wrap past 2^32.
  always_comb begin
    win_top    = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
    below_base = {1'b0, pc_q} < {1'b0, IMEM_BASE};
    above_top  = {1'b0, pc_q} >= win_top;
    addr_bad   = (pc_q[1:0] != 2'b00) | below_base | above_top;
  end

  assign imem_req   = (state_q == StReq) & ~addr_bad & ~reset;
  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == StReq) & ~addr_bad & ~imem_ack;

  assign pc_f    = pc_q;
  assign pc_d    = pc_d_q;
  assign instr_d = instr_d_q;
  assign valid_d = valid_d_q;
  assign adel_d  = adel_d_q;

  // D is never fed a bubble: it simply freezes while IF waits or holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      pc_d_q      <= '0;
      instr_d_q   <= '0;
      valid_d_q   <= 1'b0;
      adel_d_q    <= 1'b0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (addr_bad) begin
            if (!stall_i) begin
              pc_d_q    <= pc_q;
              instr_d_q <= '0;
              valid_d_q <= 1'b1;
              adel_d_q  <= 1'b1;
              pc_q      <= npc_i;
            end
          end else if (imem_ack) begin
            if (!stall_i) begin
              pc_d_q    <= pc_q;
              instr_d_q <= imem_rdata;
              valid_d_q <= 1'b1;
              adel_d_q  <= 1'b0;
              pc_q      <= npc_i;
            end else begin
              buf_pc_q    <= pc_q;
              buf_instr_q <= imem_rdata;
              state_q     <= StHold;
            end
          end
        end
        StHold: begin
          if (!stall_i) begin
            pc_d_q    <= buf_pc_q;
            instr_d_q <= buf_instr_q;
            valid_d_q <= 1'b1;
            adel_d_q  <= 1'b0;
            pc_q      <= npc_i;
            state_q   <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

endmodule
